// File: rtl/muldiv_iter_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// Also used by decode, which routes ops here when funct7 equals M_FUNCT7.
package muldiv_iter_pkg;

   localparam logic [6:0] M_FUNCT7 = 7'b0000001;

   localparam logic [2:0] MULDIV_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_REM    = 3'b110;
   localparam logic [2:0] MULDIV_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic rs1_is_signed(input logic [2:0] f3);
      return (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
             (f3 == MULDIV_DIV)  || (f3 == MULDIV_REM);
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] f3);
      return (f3 == MULDIV_MULH) || (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restore-subtract for divide, both operating on a 2*XLEN accumulator.
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_partial;
   logic [XLEN-1:0] div_diff;
   logic [XLEN-1:0] div_rem;
   logic            div_ge;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   always_comb begin
      mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]};
      if (acc_i[0]) begin
         mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
      end
   end

   // Divide: acc = {remainder, dividend bits still to consume / quotient bits}.
   // The true difference is always below the divisor, so XLEN bits hold it.
   always_comb begin
      div_partial = acc_i[2*XLEN-1:XLEN-1];
      div_ge      = (div_partial >= {1'b0, opnd_i});
      div_diff    = div_partial[XLEN-1:0] - opnd_i;
      div_rem     = div_ge ? div_diff : div_partial[XLEN-1:0];
   end

   always_comb begin
      if (is_div_i) begin
         acc_o = {div_rem, acc_i[XLEN-2:0], div_ge};
      end else begin
         acc_o = {mul_sum, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Handshake: an op transfers on an edge with i_valid && ow_ready && !i_flush; a result transfers on an edge with or_valid && i_ready && !i_flush.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int XADDR = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             ow_ready,
   input  logic [2:0]       i_funct3,
   input  logic [XLEN-1:0]  i_rs1_data,
   input  logic [XLEN-1:0]  i_rs2_data,
   input  logic [XADDR-1:0] i_rd_addr,
   input  logic             i_flush,
   input  logic             i_ready,
   output logic             or_valid,
   output logic [XADDR-1:0] or_rd_addr,
   output logic [XLEN-1:0]  or_result,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              s1_q, s1_d, s2_q, s2_d;
   logic [2:0]        f3_q, f3_d;
   logic [XADDR-1:0]  rd_q, rd_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              accept;
   logic              sign1, sign2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf;
   logic [2*XLEN-1:0] prod_f;
   logic [XLEN-1:0]   quo_f, rem_f, fix_res;

   muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .is_div_i (f3_q[2]),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_step)
   );

   // Magnitudes of the operands; abs(most negative) keeps its bit pattern.
   always_comb begin
      accept   = i_valid && (state_q == ST_IDLE) && !i_flush;
      sign1    = rs1_is_signed(i_funct3) && i_rs1_data[XLEN-1];
      sign2    = rs2_is_signed(i_funct3) && i_rs2_data[XLEN-1];
      mag1     = sign1 ? (~i_rs1_data + ONE_X) : i_rs1_data;
      mag2     = sign2 ? (~i_rs2_data + ONE_X) : i_rs2_data;
      div_zero = i_funct3[2] && (i_rs2_data == '0);
      div_ovf  = ((i_funct3 == MULDIV_DIV) || (i_funct3 == MULDIV_REM)) &&
                 (i_rs1_data == MIN_X) && (i_rs2_data == '1);
   end

   always_comb begin
      prod_f = (s1_q ^ s2_q) ? (~acc_q + ONE_2X) : acc_q;
      quo_f  = (s1_q ^ s2_q) ? (~acc_q[XLEN-1:0] + ONE_X) : acc_q[XLEN-1:0];
      rem_f  = s1_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_X) : acc_q[2*XLEN-1:XLEN];
      case (f3_q)
         MULDIV_MUL:                             fix_res = prod_f[XLEN-1:0];
         MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_res = prod_f[2*XLEN-1:XLEN];
         MULDIV_DIV, MULDIV_DIVU:                fix_res = quo_f;
         default:                                fix_res = rem_f;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               f3_d   = i_funct3;
               rd_d   = i_rd_addr;
               s1_d   = sign1;
               s2_d   = sign2;
               opnd_d = mag2;
               acc_d  = {{XLEN{1'b0}}, mag1};
               cnt_d  = CW'(XLEN);
               if (div_zero) begin
                  res_d   = i_funct3[1] ? i_rs1_data : '1;
                  state_d = ST_DONE;
               end else if (div_ovf) begin
                  res_d   = i_funct3[1] ? '0 : i_rs1_data;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_FIXUP;
            end
         end
         ST_FIXUP: begin
            if (!i_flush) begin
               res_d = fix_res;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A redirect kills whatever is in flight, including a pending result.
      if (i_flush) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         f3_q    <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   assign ow_ready    = (state_q == ST_IDLE);
   assign or_valid    = (state_q == ST_DONE);
   assign or_rd_addr  = rd_q;
   assign or_result   = res_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table for every M-op and the special
// division cases, then hand-written backpressure, flush and reset sequences.
module tb_muldiv_iter;
   import muldiv_iter_pkg::*;

   localparam int XLEN  = 32;
   localparam int XADDR = 5;

   logic             i_clk;
   logic             i_rst;
   logic             i_valid;
   logic             ow_ready;
   logic [2:0]       i_funct3;
   logic [XLEN-1:0]  i_rs1_data;
   logic [XLEN-1:0]  i_rs2_data;
   logic [XADDR-1:0] i_rd_addr;
   logic             i_flush;
   logic             i_ready;
   logic             or_valid;
   logic [XADDR-1:0] or_rd_addr;
   logic [XLEN-1:0]  or_result;
   logic [1:0]       o_dbg_state;

   muldiv_iter #(.XLEN(XLEN), .XADDR(XADDR)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .ow_ready    (ow_ready),
      .i_funct3    (i_funct3),
      .i_rs1_data  (i_rs1_data),
      .i_rs2_data  (i_rs2_data),
      .i_rd_addr   (i_rd_addr),
      .i_flush     (i_flush),
      .i_ready     (i_ready),
      .or_valid    (or_valid),
      .or_rd_addr  (or_rd_addr),
      .or_result   (or_result),
      .o_dbg_state (o_dbg_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0]      f3;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp;
      int              lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one op, wait (bounded) for or_valid; leaves i_ready untouched.
   task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XADDR-1:0] rd,
                         output logic [XLEN-1:0] res, output logic [XADDR-1:0] rd_o,
                         output int lat, output logic rdy_bad);
      i_funct3   = f3;
      i_rs1_data = a;
      i_rs2_data = b;
      i_rd_addr  = rd;
      i_valid    = 1'b1;
      @(posedge i_clk);
      lat = 1;
      #1;
      i_valid = 1'b0;
      rdy_bad = 1'b0;
      while (!or_valid && lat < 100) begin
         if (ow_ready) rdy_bad = 1'b1;
         @(posedge i_clk);
         lat++;
         #1;
      end
      res  = or_result;
      rd_o = or_rd_addr;
   endtask

   task automatic handshake();
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [XLEN-1:0]  res, hold_res;
      logic [XADDR-1:0] rd_o, hold_rd;
      int               lat;
      logic             rdy_bad, seen;

      vecs[0]  = '{MULDIV_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vecs[3]  = '{MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[4]  = '{MULDIV_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
      vecs[5]  = '{MULDIV_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
      vecs[6]  = '{MULDIV_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34};
      vecs[7]  = '{MULDIV_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34};
      vecs[8]  = '{MULDIV_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[9]  = '{MULDIV_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
      vecs[10] = '{MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{MULDIV_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
      vecs[13] = '{MULDIV_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34};
      vecs[14] = '{MULDIV_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 34};
      vecs[15] = '{MULDIV_MULH,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 34};

      i_rst      = 1'b1;
      i_valid    = 1'b0;
      i_funct3   = '0;
      i_rs1_data = '0;
      i_rs2_data = '0;
      i_rd_addr  = '0;
      i_flush    = 1'b0;
      i_ready    = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_valid", 64'(or_valid), 64'd0);
      chk("reset_result", 64'(or_result), 64'd0);
      chk("reset_rd", 64'(or_rd_addr), 64'd0);
      chk("reset_ready", 64'(ow_ready), 64'd1);
      chk("reset_state", 64'(o_dbg_state), 64'(ST_IDLE));
      i_rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         chk($sformatf("v%0d_ready_idle", i), 64'(ow_ready), 64'd1);
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, XADDR'(i + 1), res, rd_o, lat, rdy_bad);
         chk($sformatf("v%0d_result", i), 64'(res), 64'(vecs[i].exp));
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_rd", i), 64'(rd_o), 64'(i + 1));
         chk($sformatf("v%0d_ready_busy", i), 64'(rdy_bad), 64'd0);
         handshake();
         chk($sformatf("v%0d_valid_after_hs", i), 64'(or_valid), 64'd0);
      end

      // Backpressure: result held while i_ready is low, new op refused.
      i_ready = 1'b0;
      run_op(MULDIV_DIVU, 32'd100, 32'd7, 5'd9, res, rd_o, lat, rdy_bad);
      chk("bp_result", 64'(res), 64'd14);
      hold_res = or_result;
      hold_rd  = or_rd_addr;
      for (int k = 0; k < 5; k++) begin
         i_valid    = 1'b1;
         i_funct3   = MULDIV_MUL;
         i_rs1_data = 32'd1;
         i_rs2_data = 32'd1;
         i_rd_addr  = 5'd3;
         @(posedge i_clk);
         #1;
         chk($sformatf("bp%0d_valid", k), 64'(or_valid), 64'd1);
         chk($sformatf("bp%0d_result", k), 64'(or_result), 64'(hold_res));
         chk($sformatf("bp%0d_rd", k), 64'(or_rd_addr), 64'(hold_rd));
         chk($sformatf("bp%0d_ready", k), 64'(ow_ready), 64'd0);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      chk("bp_release_state", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("bp_release_ready", 64'(ow_ready), 64'd1);
      chk("bp_release_valid", 64'(or_valid), 64'd0);

      // Flush during the tenth CALC cycle.
      i_funct3   = MULDIV_MUL;
      i_rs1_data = 32'd11;
      i_rs2_data = 32'd13;
      i_rd_addr  = 5'd4;
      i_valid    = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      chk("flush_in_calc", 64'(o_dbg_state), 64'(ST_CALC));
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("flush_state", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("flush_ready", 64'(ow_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge i_clk);
         #1;
         if (or_valid) seen = 1'b1;
      end
      chk("flush_no_valid", 64'(seen), 64'd0);

      // Flush together with a request in IDLE: nothing accepted.
      i_valid = 1'b1;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      chk("flush_idle_state", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("flush_idle_ready", 64'(ow_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge i_clk);
         #1;
         if (or_valid) seen = 1'b1;
      end
      chk("flush_idle_no_valid", 64'(seen), 64'd0);

      // Reset in the middle of CALC, then a normal op.
      i_funct3   = MULDIV_MUL;
      i_rs1_data = 32'd9;
      i_rs2_data = 32'd9;
      i_rd_addr  = 5'd17;
      i_valid    = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      #1;
      chk("rst_pre_rd", 64'(or_rd_addr), 64'd17);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      chk("rst_valid", 64'(or_valid), 64'd0);
      chk("rst_result", 64'(or_result), 64'd0);
      chk("rst_rd", 64'(or_rd_addr), 64'd0);
      chk("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("rst_ready", 64'(ow_ready), 64'd1);

      run_op(MULDIV_MUL, 32'd3, 32'd4, 5'd6, res, rd_o, lat, rdy_bad);
      chk("post_rst_result", 64'(res), 64'd12);
      chk("post_rst_latency", 64'(lat), 64'd34);
      chk("post_rst_rd", 64'(rd_o), 64'd6);
      handshake();
      chk("post_rst_idle", 64'(ow_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
